traffic_light_ctrl_timed: RTL



---
 rtl/traffic_pkg.sv | 59 +++++
 rtl/traffic_light_ctrl_timed_phase_timer.sv | 36 +++
 rtl/traffic_light_ctrl_timed.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the timed traffic-light controller.
//   state_t     - 3-bit phase encoding, also exported on the debug phase port
//   lamps_t     - packed bundle of the seven lamp outputs
//   dur_ticks   - maps a phase to its dwell time in ticks
//   lamp_decode - Moore lamp decode of a phase (plus blink bit for FLASH)
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6,
        FLASH     = 3'd7
    } state_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    // FLASH is untimed (it leaves on flash_en=0), so it reports a dummy 1.
    function automatic int dur_ticks(input state_t s, input int green_t,
                                     input int yellow_t, input int allred_t,
                                     input int walk_t);
        case (s)
            NS_GREEN, EW_GREEN:   dur_ticks = green_t;
            NS_YELLOW, EW_YELLOW: dur_ticks = yellow_t;
            ALLRED_NS, ALLRED_EW: dur_ticks = allred_t;
            WALK:                 dur_ticks = walk_t;
            default:              dur_ticks = 1;
        endcase
    endfunction

    // Every non-flash phase keeps at least the opposing approach red, so a
    // conflicting green/yellow pair can never be decoded.
    function automatic lamps_t lamp_decode(input state_t s, input logic blink);
        lamps_t l;
        l = 7'b0;
        case (s)
            NS_GREEN:  begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
            NS_YELLOW: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
            EW_GREEN:  begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
            EW_YELLOW: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
            WALK:      begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
            FLASH:     begin l.ns_yellow = blink; l.ew_yellow = blink; end
            default:   begin l.ns_red = 1'b1; l.ew_red = 1'b1; end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_timed_phase_timer.sv
// phase_timer: loadable down-counter pacing every timed phase.
//   clk, rst  - system clock, asynchronous active-high reset (count=RST_VAL)
//   load      - reload count with load_val (takes priority over tick)
//   load_val  - duration-1 of the phase being entered
//   tick      - timing strobe; count decrements only on tick
//   expired   - tick arriving while count==0 (phase ends on this edge)
module phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    // Down-counter: reload on phase entry, otherwise count ticks down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_W'(RST_VAL);
        end else if (load) begin
            count_r <= load_val;
        end else if (tick && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = tick && (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/traffic_light_ctrl_timed.sv
// traffic_light_ctrl_timed: two-approach signal controller with all-red
// clearance, latched pedestrian walk and flashing-yellow mode.
//   clk, rst                 - system clock, asynchronous active-high reset
//   tick                     - timing strobe pacing all dwell times
//   ped_req                  - pedestrian button, latched every clk
//   flash_en                 - request flashing yellow (entered from all-red)
//   ns_*/ew_* lamps, walk    - registered Moore lamp outputs
//   ped_pending              - latched pedestrian request
//   phase                    - current state encoding (debug)
module traffic_light_ctrl_timed
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam int MAX_TICKS = 1 << CNT_W;
    localparam bit DUR_OK =
        (GREEN_TICKS  >= 1) && (GREEN_TICKS  <= MAX_TICKS) &&
        (YELLOW_TICKS >= 1) && (YELLOW_TICKS <= MAX_TICKS) &&
        (ALLRED_TICKS >= 1) && (ALLRED_TICKS <= MAX_TICKS) &&
        (WALK_TICKS   >= 1) && (WALK_TICKS   <= MAX_TICKS);

    if (!DUR_OK) begin : g_bad_duration
        $error("traffic_light_ctrl_timed: every duration must be in 1..2**CNT_W");
    end

    state_t           state_r;
    state_t           next_state_s;
    logic             blink_r;
    logic             blink_next_s;
    logic             ped_pending_r;
    logic             pending_next_s;
    logic             state_change_s;
    logic             expired_s;
    logic [CNT_W-1:0] load_val_s;
    lamps_t           lamps_r;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_TICKS - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_change_s),
        .load_val (load_val_s),
        .tick     (tick),
        .expired  (expired_s)
    );

    // Next-phase selection; flash is only reachable from the all-red phases.
    always_comb begin
        next_state_s = state_r;
        blink_next_s = blink_r;
        case (state_r)
            ALLRED_NS: begin
                if (expired_s) begin
                    if (flash_en) begin
                        next_state_s = FLASH;
                        blink_next_s = 1'b1;
                    end else if (ped_pending_r) begin
                        next_state_s = WALK;
                    end else begin
                        next_state_s = NS_GREEN;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            ALLRED_EW: begin
                if (expired_s) begin
                    if (flash_en) begin
                        next_state_s = FLASH;
                        blink_next_s = 1'b1;
                    end else begin
                        next_state_s = EW_GREEN;
                    end
                end else begin
                    next_state_s = state_r;
                end
            end
            NS_GREEN:  begin if (expired_s) next_state_s = NS_YELLOW; else next_state_s = state_r; end
            NS_YELLOW: begin if (expired_s) next_state_s = ALLRED_EW; else next_state_s = state_r; end
            EW_GREEN:  begin if (expired_s) next_state_s = EW_YELLOW; else next_state_s = state_r; end
            EW_YELLOW: begin if (expired_s) next_state_s = ALLRED_NS; else next_state_s = state_r; end
            WALK:      begin if (expired_s) next_state_s = NS_GREEN;  else next_state_s = state_r; end
            FLASH: begin
                if (tick && !flash_en) begin
                    next_state_s = ALLRED_NS;
                end else if (tick) begin
                    blink_next_s = ~blink_r;
                end else begin
                    blink_next_s = blink_r;
                end
            end
            default: next_state_s = ALLRED_NS;
        endcase
    end

    // Timer reload and pedestrian latch; a request on the WALK-entry cycle is
    // absorbed by that walk.
    always_comb begin
        state_change_s = (next_state_s != state_r);
        load_val_s     = CNT_W'(dur_ticks(next_state_s, GREEN_TICKS, YELLOW_TICKS,
                                          ALLRED_TICKS, WALK_TICKS) - 1);
        pending_next_s = (state_change_s && (next_state_s == WALK)) ? 1'b0
                                                                    : (ped_pending_r | ped_req);
    end

    // State, latches and lamps; lamps are decoded from the next state so they
    // change on the same edge as the phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ALLRED_NS;
            blink_r       <= 1'b0;
            ped_pending_r <= 1'b0;
            lamps_r       <= lamp_decode(ALLRED_NS, 1'b0);
        end else begin
            state_r       <= next_state_s;
            blink_r       <= blink_next_s;
            ped_pending_r <= pending_next_s;
            lamps_r       <= lamp_decode(next_state_s, blink_next_s);
        end
    end

    assign ns_red      = lamps_r.ns_red;
    assign ns_yellow   = lamps_r.ns_yellow;
    assign ns_green    = lamps_r.ns_green;
    assign ew_red      = lamps_r.ew_red;
    assign ew_yellow   = lamps_r.ew_yellow;
    assign ew_green    = lamps_r.ew_green;
    assign walk        = lamps_r.walk;
    assign ped_pending = ped_pending_r;
    assign phase       = state_r;

endmodule
